tcb_gpio_arb: RTL
=================

TCB_GPIO_ARB -- requirements
Module: tcb_gpio_arb

Interface
REQ-001 SHALL have parameter RN, default 2: number of requesters (2..8).
REQ-002 SHALL have parameter GW, default 32: GPIO data width.
REQ-003 SHALL have parameter AW, default 4: register address width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_vld  input  RN  per-requester request valid.
REQ-007 SHALL have port req_lck  input  RN  per-requester lock, held with vld.
REQ-008 SHALL have port req_wen  input  RN  per-requester write enable.
REQ-009 SHALL have port req_adr  input  RN*AW  per-requester address, requester i at [i*AW+:AW].
REQ-010 SHALL have port req_wdt  input  RN*GW  per-requester write data, requester i at [i*GW+:GW].
REQ-011 SHALL have port req_rdy  output  RN  per-requester ready.
REQ-012 SHALL have port rsp_vld  output  RN  per-requester response valid.
REQ-013 SHALL have port rsp_rdt  output  GW  shared read data.
REQ-014 SHALL have ports mgr_vld/mgr_wen (output 1), mgr_adr (output AW), mgr_wdt (output GW): request to GPIO controller.
REQ-015 SHALL have ports mgr_rdy (input 1), mgr_rdt (input GW): GPIO controller ready and read data (DLY=1).

Function
REQ-016 SHALL grant combinationally the lowest index i, counting cyclically from pointer ptr, with req_vld[i]=1.
REQ-017 SHALL drive mgr_vld=|req_vld; mgr_wen/adr/wdt from the granted requester; all zero when mgr_vld=0.
REQ-018 SHALL drive req_rdy[g]=mgr_rdy for granted g only; all others 0.
REQ-019 SHALL define transfer as mgr_vld & mgr_rdy; on transfer in UNLOCKED, ptr<=(g+1) mod RN (RN-1 wraps to 0).
REQ-020 SHALL keep ptr unchanged when no transfer occurs, including mgr_rdy=0 stalls.
REQ-021 SHALL assert rsp_vld[g] exactly one cycle after a transfer by g; rsp_rdt=mgr_rdt passthrough in that cycle.
REQ-022 SHALL keep rsp_vld one-hot or zero; back-to-back transfers yield back-to-back responses.
REQ-023 SHALL implement FSM UNLOCKED/LOCKED with owner register own.
REQ-024 UNLOCKED->LOCKED on transfer with req_lck[g]=1; own<=g.
REQ-025 In LOCKED, grant SHALL be own only (others masked, even if own drops vld); ptr frozen.
REQ-026 LOCKED->UNLOCKED on transfer by own with req_lck[own]=0; ptr<=(own+1) mod RN.
REQ-027 Lock with req_lck asserted and no transfer SHALL not change state.

Reset
REQ-028 While rst_n=0: ptr=0, state=UNLOCKED, own=0, rsp_vld=0; combinational outputs follow inputs.
REQ-029 Reset mid-transfer or mid-lock SHALL discard pending response and lock; first cycle after release grants from index 0.

Configuration
REQ-030 Macro TCB_GPIO_ARB_LOCK_EN SHALL compile in REQ-023..REQ-027.
REQ-031 Without TCB_GPIO_ARB_LOCK_EN: req_lck port present but ignored, no FSM/own register, pure round-robin.

Structure
REQ-032 Package tcb_gpio_arb_pkg SHALL hold GPIO register offsets (0x0 output, 0x4 enable, 0x8 input) and the state enum.
REQ-033 Sub-module tcb_gpio_arb_rr SHALL implement the cyclic priority encoder (inputs vld, ptr; outputs grant index, any).

Verification
REQ-034 RN=2, both vld every cycle, mgr_rdy=1 -> grants 0,1,0,1; rsp_vld 01,10,01,10 one cycle delayed.
REQ-035 Requester 1 only, mgr_rdy low 3 cycles -> mgr_adr held, req_rdy=2'b00 then 2'b10 on one cycle, ptr 0->0.
REQ-036 Read adr=0x8, mgr_rdt=32'hA5A5_0F0F next cycle -> rsp_vld[0]=1, rsp_rdt=32'hA5A5_0F0F.
REQ-037 LOCK_EN: req0 lck=1 write 0x0, read 0x4 with lck=0 while req1 vld -> req1 granted only after unlock; ptr=1.
REQ-038 rst_n low for 1 cycle during transfer cycle -> next cycle rsp_vld=0, state UNLOCKED, grant index 0.
REQ-039 RN=3, ptr=2, req_vld=3'b011 -> grant 0 (wrap), then ptr=1.

Source files
------------

// File: rtl/tcb_gpio_arb_pkg.sv
// Shared definitions for the TCB GPIO arbiter: GPIO register map and lock FSM encoding.
package tcb_gpio_arb_pkg;

    localparam logic [7:0] GPIO_OUT_OFS = 8'h00;
    localparam logic [7:0] GPIO_ENA_OFS = 8'h04;
    localparam logic [7:0] GPIO_INP_OFS = 8'h08;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/tcb_gpio_arb_rr.sv
// Cyclic priority encoder: selects the first set vld bit starting at ptr and wrapping.
module tcb_gpio_arb_rr #(
    parameter int unsigned RN = 2,
    parameter int unsigned PW = 1
) (
    input  logic [RN-1:0] vld,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt,
    output logic          any
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest valid index wins last.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        sum = '0;
        idx = '0;
        for (int unsigned k = RN; k > 0; k--) begin
            sum = {1'b0, ptr} + (PW+1)'(k - 1);
            if (sum >= (PW+1)'(RN)) begin
                sum = sum - (PW+1)'(RN);
            end
            idx = sum[PW-1:0];
            if (vld[idx]) begin
                gnt = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcb_gpio_arb.sv
// Round-robin arbiter of RN TCB requesters onto one GPIO controller port.
// Define TCB_GPIO_ARB_LOCK_EN to add the UNLOCKED/LOCKED ownership FSM.
module tcb_gpio_arb
    import tcb_gpio_arb_pkg::*;
#(
    parameter int unsigned RN = 2,
    parameter int unsigned GW = 32,
    parameter int unsigned AW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RN-1:0]    req_vld,
    input  logic [RN-1:0]    req_lck,
    input  logic [RN-1:0]    req_wen,
    input  logic [RN*AW-1:0] req_adr,
    input  logic [RN*GW-1:0] req_wdt,
    output logic [RN-1:0]    req_rdy,
    output logic [RN-1:0]    rsp_vld,
    output logic [GW-1:0]    rsp_rdt,
    output logic             mgr_vld,
    output logic             mgr_wen,
    output logic [AW-1:0]    mgr_adr,
    output logic [GW-1:0]    mgr_wdt,
    input  logic             mgr_rdy,
    input  logic [GW-1:0]    mgr_rdt
);

    localparam int unsigned PW = (RN > 1) ? $clog2(RN) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt;
    logic [PW-1:0] gnt_inc;
    logic          any;
    logic [RN-1:0] vld_eff;
    logic          xfer;
    logic          ptr_upd;

    tcb_gpio_arb_rr #(
        .RN (RN),
        .PW (PW)
    ) u_rr (
        .vld (vld_eff),
        .ptr (ptr),
        .gnt (gnt),
        .any (any)
    );

    assign xfer    = any & mgr_rdy;
    assign gnt_inc = (gnt == PW'(RN - 1)) ? '0 : gnt + 1'b1;

`ifdef TCB_GPIO_ARB_LOCK_EN
    arb_state_e    state;
    arb_state_e    state_nxt;
    logic [PW-1:0] own;
    logic          locked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_UNLOCKED;
            own   <= '0;
        end else begin
            state <= state_nxt;
            if (xfer && (state == ST_UNLOCKED) && req_lck[gnt]) begin
                own <= gnt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_UNLOCKED: if (xfer && req_lck[gnt])  state_nxt = ST_LOCKED;
            ST_LOCKED:   if (xfer && !req_lck[own]) state_nxt = ST_UNLOCKED;
            default:     state_nxt = ST_UNLOCKED;
        endcase
    end

    // While locked only the owner can win, so gnt == own on any transfer and
    // the unlocking transfer advances ptr to own+1 through the common path.
    always_comb begin
        locked  = (state == ST_LOCKED);
        vld_eff = locked ? (req_vld & (RN'(1) << own)) : req_vld;
        ptr_upd = xfer & (~locked | ~req_lck[own]);
    end
`else
    logic unused_lck;
    assign unused_lck = ^req_lck;

    always_comb begin
        vld_eff = req_vld;
        ptr_upd = xfer;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            rsp_vld <= '0;
        end else begin
            if (ptr_upd) begin
                ptr <= gnt_inc;
            end
            rsp_vld <= xfer ? (RN'(1) << gnt) : '0;
        end
    end

    always_comb begin
        mgr_vld = any;
        mgr_wen = 1'b0;
        mgr_adr = '0;
        mgr_wdt = '0;
        req_rdy = '0;
        if (any) begin
            mgr_wen = req_wen[gnt];
            mgr_adr = req_adr[32'(gnt)*AW +: AW];
            mgr_wdt = req_wdt[32'(gnt)*GW +: GW];
            req_rdy = RN'(mgr_rdy) << gnt;
        end
    end

    assign rsp_rdt = mgr_rdt;

endmodule
